// File: rtl/bcd_add_pkg.sv
// Shared definitions for the serial BCD adder controller: state encoding,
// digit constants and the datapath digit width.
package bcd_add_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUM,
        WAIT,
        FIX,
        NEXT,
        DONE
    } state_t;

    localparam int          C_W     = 5;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_FIX = 4'd6;

    // A raw digit sum needs the +6 correction when it is strictly above 9.
    function automatic logic needs_fix(input logic [C_W-1:0] c);
        return c > {1'b0, BCD_MAX};
    endfunction

endpackage

// File: rtl/bcd_add_ctrl.sv
// Control FSM for the n-digit serial BCD adder datapath. Walks the digits
// least significant first, issuing sum / settle / +6 / carry / index strobes,
// and reports busy and a one-cycle done pulse.
// Optional macro BCD_ADD_CARRY_OUT_EN adds a carry_out port holding the carry
// out of the most significant digit; without it that carry is discarded.
module bcd_add_ctrl
    import bcd_add_pkg::*;
#(
    parameter int N_DIGITS = 6,
    parameter int S_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [S_W-1:0] s_in,
    input  logic [4:0]     c_cur,
    output logic           state_load,
    output logic           state_sum,
    output logic           state_wait,
    output logic           state_plus_6_c,
    output logic           state_inc_c,
    output logic           state_inc_s,
    output logic           busy,
    output logic           done
`ifdef BCD_ADD_CARRY_OUT_EN
    ,
    output logic           carry_out
`endif
);

    localparam logic [S_W-1:0] LAST_S = S_W'(N_DIGITS - 1);

    state_t state_q;
    state_t state_d;
    logic   last_digit;

    assign last_digit = (s_in == LAST_S);

    // State register, cleared asynchronously when rst is pulled low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one digit per SUM/WAIT/[FIX]/NEXT loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = SUM;
            SUM:     state_d = WAIT;
            WAIT:    state_d = needs_fix(c_cur) ? FIX : NEXT;
            FIX:     state_d = NEXT;
            NEXT:    state_d = last_digit ? DONE : SUM;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the registered state; the carry into the next digit is
    // suppressed on the last digit so nothing is written past the top.
    always_comb begin
        state_load     = 1'b0;
        state_sum      = 1'b0;
        state_wait     = 1'b0;
        state_plus_6_c = 1'b0;
        state_inc_c    = 1'b0;
        state_inc_s    = 1'b0;
        done           = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            LOAD:    state_load = 1'b1;
            SUM:     state_sum  = 1'b1;
            WAIT:    state_wait = 1'b1;
            FIX: begin
                state_plus_6_c = 1'b1;
                state_inc_c    = !last_digit;
            end
            NEXT:    state_inc_s = !last_digit;
            DONE:    done        = 1'b1;
            default: ;
        endcase
    end

`ifdef BCD_ADD_CARRY_OUT_EN
    logic carry_q;
    logic carry_d;

    // Carry out of the top digit: cleared on load, set when the top digit is corrected.
    always_comb begin
        carry_d = carry_q;
        if (state_q == LOAD) begin
            carry_d = 1'b0;
        end else if (state_q == FIX && last_digit) begin
            carry_d = 1'b1;
        end
    end

    // Carry-out register, holds from DONE until the next LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_bcd_add_ctrl.sv
// Directed self-checking bench for bcd_add_ctrl with a behavioural model of
// the serial BCD datapath closing the loop on s_in / c_cur.
module tb_bcd_add_ctrl;

    localparam int N   = 6;
    localparam int S_W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [S_W-1:0] s_in;
    logic [4:0]     c_cur;
    logic           state_load;
    logic           state_sum;
    logic           state_wait;
    logic           state_plus_6_c;
    logic           state_inc_c;
    logic           state_inc_s;
    logic           busy;
    logic           done;
`ifdef BCD_ADD_CARRY_OUT_EN
    logic           carry_out;
`endif

    int checks   = 0;
    int failures = 0;

    logic [23:0] opA;
    logic [23:0] opB;
    logic [3:0]  aDig [N];
    logic [3:0]  bDig [N];
    logic [4:0]  cReg [N];
    logic [S_W-1:0] sReg;

    bcd_add_ctrl #(.N_DIGITS(N), .S_W(S_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_in           (s_in),
        .c_cur          (c_cur),
        .state_load     (state_load),
        .state_sum      (state_sum),
        .state_wait     (state_wait),
        .state_plus_6_c (state_plus_6_c),
        .state_inc_c    (state_inc_c),
        .state_inc_s    (state_inc_s),
        .busy           (busy),
        .done           (done)
`ifdef BCD_ADD_CARRY_OUT_EN
        ,
        .carry_out      (carry_out)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapath: digit 0 is the least significant digit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sReg <= '0;
            for (int d = 0; d < N; d++) cReg[d] <= '0;
        end else begin
            if (state_load) begin
                sReg <= '0;
                for (int d = 0; d < N; d++) begin
                    aDig[d] <= opA[4*d +: 4];
                    bDig[d] <= opB[4*d +: 4];
                    cReg[d] <= '0;
                end
            end
            if (state_sum && int'(sReg) < N)
                cReg[int'(sReg)] <= cReg[int'(sReg)] + {1'b0, aDig[int'(sReg)]} + {1'b0, bDig[int'(sReg)]};
            if (state_plus_6_c && int'(sReg) < N)
                cReg[int'(sReg)] <= cReg[int'(sReg)] + 5'd6;
            if (state_inc_c && int'(sReg) < N - 1)
                cReg[int'(sReg) + 1] <= cReg[int'(sReg) + 1] + 5'd1;
            if (state_inc_s)
                sReg <= sReg + 1'b1;
        end
    end

    assign s_in  = sReg;
    assign c_cur = (int'(sReg) < N) ? cReg[int'(sReg)] : 5'd0;

    // Low nibble of every model digit, assembled as a packed BCD number.
    function automatic logic [23:0] result();
        logic [23:0] r;
        r = '0;
        for (int d = 0; d < N; d++) r[4*d +: 4] = cReg[d][3:0];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    int doneAt, nFix, nIncC, incAtLast, nSum, nWait, nIncS, nLoad, badHot, busyGap, doneCount;

    // Runs one addition from a one-cycle start pulse and gathers strobe statistics.
    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b, input bit midPulse);
        int k;
        int hot;
        opA = a;
        opB = b;
        doneAt = -1; nFix = 0; nIncC = 0; incAtLast = 0; nSum = 0; nWait = 0;
        nIncS = 0; nLoad = 0; badHot = 0; busyGap = 0; doneCount = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k <= 120) begin
            hot = int'(state_load) + int'(state_sum) + int'(state_wait) +
                  int'(state_plus_6_c) + int'(state_inc_s) + int'(done);
            if (hot > 1 || (state_inc_c && !state_plus_6_c)) badHot++;
            if (state_load) nLoad++;
            if (state_sum) nSum++;
            if (state_wait) nWait++;
            if (state_plus_6_c) nFix++;
            if (state_inc_c) nIncC++;
            if (state_inc_c && int'(s_in) == N - 1) incAtLast++;
            if (state_inc_s) nIncS++;
            if (done) begin
                doneCount++;
                if (doneAt < 0) doneAt = k;
            end
            if (doneAt < 0 && !busy) busyGap++;
            start = midPulse && (k == 4 || k == 11);
            if (doneAt >= 0 && k >= doneAt + 3) break;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
    endtask

    int k6, firstDone, secondDone;
    logic idleBusy, loadSeen;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        opA   = '0;
        opB   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {24'd0, state_load, state_sum, state_wait, state_plus_6_c,
                     state_inc_c, state_inc_s, busy, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_release", {31'd0, busy}, 32'd0);

        $display("[TB] plain add 123456+111111");
        applyStimulus(24'h123456, 24'h111111, 1'b0);
        checkOutput("t1_done_at", doneAt, 20);
        checkOutput("t1_plus6", nFix, 0);
        checkOutput("t1_inc_c", nIncC, 0);
        checkOutput("t1_sum_cnt", nSum, 6);
        checkOutput("t1_wait_cnt", nWait, 6);
        checkOutput("t1_inc_s_cnt", nIncS, 5);
        checkOutput("t1_load_cnt", nLoad, 1);
        checkOutput("t1_one_hot", badHot, 0);
        checkOutput("t1_result", result(), 24'h234567);

        $display("[TB] single fix 000009+000001");
        applyStimulus(24'h000009, 24'h000001, 1'b0);
        checkOutput("t2_done_at", doneAt, 21);
        checkOutput("t2_plus6", nFix, 1);
        checkOutput("t2_inc_c", nIncC, 1);
        checkOutput("t2_one_hot", badHot, 0);
        checkOutput("t2_result", result(), 24'h000010);

        $display("[TB] ripple 999999+000001");
        applyStimulus(24'h999999, 24'h000001, 1'b0);
        checkOutput("t3_done_at", doneAt, 26);
        checkOutput("t3_plus6", nFix, 6);
        checkOutput("t3_inc_c", nIncC, 5);
        checkOutput("t3_inc_c_last", incAtLast, 0);
        checkOutput("t3_result", result(), 24'h000000);
`ifdef BCD_ADD_CARRY_OUT_EN
        checkOutput("t3_carry_out", {31'd0, carry_out}, 32'd1);
`endif

        $display("[TB] start pulses while busy");
        applyStimulus(24'h123456, 24'h111111, 1'b1);
        checkOutput("t4_done_at", doneAt, 20);
        checkOutput("t4_done_count", doneCount, 1);
        checkOutput("t4_busy_gap", busyGap, 0);
        checkOutput("t4_result", result(), 24'h234567);
`ifdef BCD_ADD_CARRY_OUT_EN
        checkOutput("t4_carry_out", {31'd0, carry_out}, 32'd0);
`endif

        $display("[TB] reset in WAIT of digit 3");
        opA = 24'h123456;
        opB = 24'h111111;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k6 = 1;
        while (!(state_wait && int'(s_in) == 3) && k6 < 60) begin
            @(negedge clk);
            k6++;
        end
        checkOutput("t5_wait_s3_at", k6, 12);
        rst = 1'b0;
        #1;
        checkOutput("t5_async_clear",
                    {24'd0, state_load, state_sum, state_wait, state_plus_6_c,
                     state_inc_c, state_inc_s, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(24'h123456, 24'h111111, 1'b0);
        checkOutput("t5_rerun_done_at", doneAt, 20);
        checkOutput("t5_rerun_result", result(), 24'h234567);

        $display("[TB] start held high");
        opA = 24'h123456;
        opB = 24'h111111;
        firstDone = -1;
        secondDone = -1;
        idleBusy = 1'bx;
        loadSeen = 1'bx;
        @(negedge clk);
        start = 1'b1;
        k6 = 0;
        while (secondDone < 0 && k6 < 100) begin
            @(negedge clk);
            k6++;
            if (firstDone > 0 && k6 == firstDone + 1) idleBusy = busy;
            if (firstDone > 0 && k6 == firstDone + 2) loadSeen = state_load;
            if (done) begin
                if (firstDone < 0) firstDone = k6;
                else secondDone = k6;
            end
        end
        start = 1'b0;
        checkOutput("t6_first_done", firstDone, 20);
        checkOutput("t6_idle_gap", {31'd0, idleBusy}, 32'd0);
        checkOutput("t6_load_after_idle", {31'd0, loadSeen}, 32'd1);
        checkOutput("t6_second_done", secondDone, 41);
        repeat (3) @(negedge clk);
        checkOutput("t6_back_to_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
